// File: rtl/conv_window_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// conv_window_ctrl_if : pixel-in / window-out handshake bundle
// Revision : 1.0
// ---------------------------------------------------------------------------
interface conv_window_ctrl_if #(
  parameter int ROW_W = 3,
  parameter int COL_W = 3
);
  logic             in_valid;
  logic             in_sof;
  logic             in_ready;
  logic             shift_en;
  logic             win_valid;
  logic             win_ready;
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;
  logic             frame_done;
  logic             sof_err;

  modport master (
    output in_valid, in_sof, win_ready,
    input  in_ready, shift_en, win_valid, win_row, win_col, frame_done, sof_err
  );

  modport slave (
    input  in_valid, in_sof, win_ready,
    output in_ready, shift_en, win_valid, win_row, win_col, frame_done, sof_err
  );
endinterface
`default_nettype wire

// File: rtl/conv_window_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// conv_window_ctrl : sequences pixels into a 3x3 window buffer and flags
//                    complete windows with MAC backpressure.
// Option   : CONV_WINDOW_CTRL_STRIDE2_EN -> stride-2 window emission
// Revision : 1.0
// ---------------------------------------------------------------------------
module conv_window_ctrl #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int COL_W      = $clog2(IMG_WIDTH),
  parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  conv_window_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  state_t           r_state, w_state_nxt;
  logic [ROW_W-1:0] r_row, w_row_nxt;
  logic [COL_W-1:0] r_col, w_col_nxt;
  logic             r_win_valid, w_win_valid_nxt;
  logic [ROW_W-1:0] r_win_row, w_win_row_nxt;
  logic [COL_W-1:0] r_win_col, w_win_col_nxt;
  logic             r_frame_done, w_frame_done_nxt;
  logic             r_sof_err, w_sof_err_nxt;

  logic w_in_ready;
  logic w_accept;
  logic w_interior;
  logic w_win_hit;
  logic w_last;

  assign w_in_ready = ~(r_win_valid & ~bus.win_ready);
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_interior = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
  assign w_last     = (r_row == C_ROW_LAST) && (r_col == C_COL_LAST);

`ifdef CONV_WINDOW_CTRL_STRIDE2_EN
  // (r-2) and (c-2) even is the same as r and c even
  assign w_win_hit = w_interior & ~r_row[0] & ~r_col[0];
`else
  assign w_win_hit = w_interior;
`endif

  assign bus.in_ready   = w_in_ready;
  assign bus.shift_en   = w_accept & ((r_state != S_IDLE) | bus.in_sof) & ~rst;
  assign bus.win_valid  = r_win_valid;
  assign bus.win_row    = r_win_row;
  assign bus.win_col    = r_win_col;
  assign bus.frame_done = r_frame_done;
  assign bus.sof_err    = r_sof_err;

  always_comb begin
    w_state_nxt      = r_state;
    w_row_nxt        = r_row;
    w_col_nxt        = r_col;
    w_win_valid_nxt  = r_win_valid & ~bus.win_ready;
    w_win_row_nxt    = r_win_row;
    w_win_col_nxt    = r_win_col;
    w_frame_done_nxt = 1'b0;
    w_sof_err_nxt    = 1'b0;

    if (w_accept) begin
      if (bus.in_sof) begin
        // the SOF pixel itself occupies (0,0); next expected is (0,1)
        w_state_nxt   = S_FILL;
        w_row_nxt     = '0;
        w_col_nxt     = COL_W'(1);
        w_sof_err_nxt = (r_state != S_IDLE);
      end else if (r_state != S_IDLE) begin
        if (w_win_hit) begin
          w_win_valid_nxt = 1'b1;
          w_win_row_nxt   = r_row - ROW_W'(1);
          w_win_col_nxt   = r_col - COL_W'(1);
        end
        if (w_last) begin
          w_state_nxt      = S_IDLE;
          w_row_nxt        = '0;
          w_col_nxt        = '0;
          w_frame_done_nxt = 1'b1;
        end else begin
          if (r_col == C_COL_LAST) begin
            w_col_nxt = '0;
            w_row_nxt = r_row + ROW_W'(1);
          end else begin
            w_col_nxt = r_col + COL_W'(1);
          end
          if ((r_state == S_FILL) && w_interior) begin
            w_state_nxt = S_STREAM;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_win_valid  <= 1'b0;
      r_win_row    <= '0;
      r_win_col    <= '0;
      r_frame_done <= 1'b0;
      r_sof_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_row        <= w_row_nxt;
      r_col        <= w_col_nxt;
      r_win_valid  <= w_win_valid_nxt;
      r_win_row    <= w_win_row_nxt;
      r_win_col    <= w_win_col_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_sof_err    <= w_sof_err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_conv_window_ctrl : randomized bench with a frame-position reference model
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_conv_window_ctrl;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int RW = 3;
  localparam int CW = 3;
`ifdef CONV_WINDOW_CTRL_STRIDE2_EN
  localparam int STRIDE = 2;
  localparam int NWIN   = 9;
  localparam int LASTC  = 5;
  localparam int BP_R   = 3;
  localparam int BP_C   = 3;
`else
  localparam int STRIDE = 1;
  localparam int NWIN   = 36;
  localparam int LASTC  = 6;
  localparam int BP_R   = 2;
  localparam int BP_C   = 4;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_window_ctrl_if #(.ROW_W(RW), .COL_W(CW)) bus ();
  conv_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  // reference model: position of next pixel within the active frame
  bit m_active, m_pend, m_fd, m_serr;
  int m_k, m_wr, m_wc, m_acc;
  bit e_rdy, e_acc, e_se;
  int unsigned got_h, exp_h, full_h;
  int got_n, exp_n, got_last;

  task automatic model_reset();
    m_active = 0; m_pend = 0; m_fd = 0; m_serr = 0;
    m_k = 0; m_wr = 0; m_wc = 0;
  endtask

  task automatic sb_clear();
    got_h = 0; exp_h = 0; got_n = 0; exp_n = 0; got_last = -1; m_acc = 0;
  endtask

  task automatic drive(input bit v, input bit s, input bit wr);
    bus.in_valid = v; bus.in_sof = s; bus.win_ready = wr;
    #3;
    e_rdy = !(m_pend && !wr);
    e_acc = v && e_rdy;
    e_se  = e_acc && (m_active || s);
  endtask

  function automatic logic [10:0] obs();
    return {bus.in_ready, bus.shift_en, bus.win_valid, bus.frame_done, bus.sof_err,
            bus.win_row, bus.win_col};
  endfunction

  function automatic logic [10:0] expv();
    return {e_rdy, e_se, m_pend, m_fd, m_serr, 3'(m_wr), 3'(m_wc)};
  endfunction

  task automatic advance();
    int r, c, val;
    if (bus.win_valid && bus.win_ready) begin
      val = int'(bus.win_row) * 16 + int'(bus.win_col);
      got_h = got_h * 31 + val; got_n++; got_last = val;
    end
    m_fd = 0; m_serr = 0;
    if (m_pend && bus.win_ready) m_pend = 0;
    if (e_acc) begin
      m_acc++;
      if (bus.in_sof) begin
        m_serr = m_active; m_active = 1; m_k = 1;
      end else if (m_active) begin
        r = m_k / W; c = m_k % W;
        if (r >= 2 && c >= 2 && (r - 2) % STRIDE == 0 && (c - 2) % STRIDE == 0) begin
          m_pend = 1; m_wr = r - 1; m_wc = c - 1;
          exp_h = exp_h * 31 + (m_wr * 16 + m_wc); exp_n++;
        end
        m_k++;
        if (m_k == W * H) begin m_active = 0; m_k = 0; m_fd = 1; end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_sof = 1'b1; bus.win_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_chk++;
    if (obs() !== 11'b10000_000_000) begin
      n_fail++; $display("FAIL reset_outputs got %b required %b", obs(), 11'b10000_000_000);
    end
    bus.in_valid = 1'b0; bus.in_sof = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset(); sb_clear();
  endtask

  task automatic test_full_frame();
    int first, fd_cnt, fd_acc;
    sb_clear(); first = -1; fd_cnt = 0; fd_acc = -1;
    for (int i = 0; i < W * H + 4; i++) begin
      drive(i < W * H, i == 0, 1'b1);
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL full_frame cyc %0d got %b required %b", i, obs(), expv());
      end
      if (bus.win_valid && first < 0) first = m_acc;
      if (bus.frame_done) begin fd_cnt++; fd_acc = m_acc; end
      advance();
    end
    n_chk++;
    if (first !== 19) begin n_fail++; $display("FAIL first_window_after_accepts got %0d required 19", first); end
    n_chk++;
    if (got_n !== NWIN) begin n_fail++; $display("FAIL full_frame_count got %0d required %0d", got_n, NWIN); end
    n_chk++;
    if (got_last !== LASTC * 17) begin
      n_fail++; $display("FAIL last_centre got %0h required %0h", got_last, LASTC * 17);
    end
    n_chk++;
    if (fd_cnt !== 1 || fd_acc !== 64) begin
      n_fail++; $display("FAIL frame_done got count %0d at %0d required 1 at 64", fd_cnt, fd_acc);
    end
    n_chk++;
    if (got_h !== exp_h) begin n_fail++; $display("FAIL full_frame_windows got %h required %h", got_h, exp_h); end
    full_h = exp_h;
  endtask

  task automatic test_backpressure();
    int st, seen;
    bit wr;
    sb_clear(); st = 0; seen = 0;
    for (int i = 0; i < 80; i++) begin
      wr = !(m_pend && m_wr == BP_R && m_wc == BP_C && st < 3);
      if (!wr) st++;
      drive(m_acc < W * H, m_acc == 0, wr);
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL backpressure cyc %0d got %b required %b", i, obs(), expv());
      end
      if (!wr) begin
        seen++;
        n_chk++;
        if ({bus.in_ready, bus.shift_en, bus.win_row, bus.win_col} !== {2'b00, 3'(BP_R), 3'(BP_C)}) begin
          n_fail++;
          $display("FAIL stall_hold got rdy=%b se=%b (%0d,%0d) required rdy=0 se=0 (%0d,%0d)",
                   bus.in_ready, bus.shift_en, bus.win_row, bus.win_col, BP_R, BP_C);
        end
      end
      advance();
    end
    n_chk++;
    if (seen !== 3 || got_n !== NWIN || got_h !== full_h) begin
      n_fail++; $display("FAIL backpressure_windows got stalls=%0d n=%0d h=%h required 3 %0d %h",
                         seen, got_n, got_h, NWIN, full_h);
    end
  endtask

  task automatic test_drop_idle();
    sb_clear();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1);
      n_chk++;
      if (bus.shift_en !== 1'b0 || obs() !== expv()) begin
        n_fail++; $display("FAIL idle_drop cyc %0d got %b required %b", i, obs(), expv());
      end
      advance();
    end
    for (int i = 0; i < W * H + 4; i++) begin
      drive(i < W * H, i == 0, 1'b1);
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL drop_frame cyc %0d got %b required %b", i, obs(), expv());
      end
      advance();
    end
    n_chk++;
    if (got_n !== NWIN || got_h !== full_h) begin
      n_fail++; $display("FAIL drop_frame_windows got n=%0d h=%h required %0d %h", got_n, got_h, NWIN, full_h);
    end
  endtask

  task automatic test_sof_restart();
    int serr_cnt, serr_acc, fd_cnt, fd_acc, first, fc;
    sb_clear(); serr_cnt = 0; serr_acc = -1; fd_cnt = 0; fd_acc = -1; first = -1; fc = -1;
    for (int i = 0; i < 29 + W * H + 4; i++) begin
      drive(i < 29 + W * H, i == 0 || i == 29, 1'b1);
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL sof_restart cyc %0d got %b required %b", i, obs(), expv());
      end
      if (bus.sof_err) begin serr_cnt++; serr_acc = m_acc; end
      if (bus.frame_done) begin fd_cnt++; fd_acc = m_acc; end
      if (bus.win_valid && m_acc > 30 && first < 0) begin
        first = m_acc - 29; fc = int'(bus.win_row) * 16 + int'(bus.win_col);
      end
      advance();
    end
    n_chk++;
    if (serr_cnt !== 1 || serr_acc !== 30) begin
      n_fail++; $display("FAIL sof_err got count %0d at %0d required 1 at 30", serr_cnt, serr_acc);
    end
    n_chk++;
    if (first !== 19 || fc !== 17) begin
      n_fail++; $display("FAIL restart_first_window got %0d accepts centre %0h required 19 centre 11", first, fc);
    end
    n_chk++;
    if (fd_cnt !== 1 || fd_acc !== 93) begin
      n_fail++; $display("FAIL restart_frame_done got count %0d at %0d required 1 at 93", fd_cnt, fd_acc);
    end
  endtask

  task automatic test_reset_mid();
    sb_clear();
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, i == 0, 1'b1);
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL pre_reset cyc %0d got %b required %b", i, obs(), expv());
      end
      advance();
    end
    drive(1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    n_chk++;
    if (obs() !== 11'b10000_000_000) begin
      n_fail++; $display("FAIL async_reset got %b required %b", obs(), 11'b10000_000_000);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset(); sb_clear();
    for (int i = 0; i < W * H + 4; i++) begin
      drive(i < W * H, i == 0, 1'b1);
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL post_reset cyc %0d got %b required %b", i, obs(), expv());
      end
      advance();
    end
    n_chk++;
    if (got_n !== NWIN || got_h !== full_h) begin
      n_fail++; $display("FAIL post_reset_windows got n=%0d h=%h required %0d %h", got_n, got_h, NWIN, full_h);
    end
  endtask

  task automatic test_random();
    bit v, s, wr;
    sb_clear();
    for (int i = 0; i < 720; i++) begin
      if (i < 700) begin
        wr = ($urandom_range(0, 2) != 0);
        v  = ($urandom_range(0, 3) != 0);
        s  = v && ((!m_active && $urandom_range(0, 3) == 0) || ($urandom_range(0, 299) == 0));
      end else begin
        wr = 1'b1; v = 1'b0; s = 1'b0;
      end
      drive(v, s, wr);
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL random cyc %0d got %b required %b", i, obs(), expv());
      end
      advance();
    end
    n_chk++;
    if (got_n !== exp_n || got_h !== exp_h) begin
      n_fail++; $display("FAIL random_windows got n=%0d h=%h required %0d %h", got_n, got_h, exp_n, exp_h);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_drop_idle();
    test_sof_restart();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
